// File: rtl/regfile_2p.sv
// Two-port register file with per-entry valid bits, registered read port,
// optional write-to-read forwarding and a sequential clear sweep.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | normal operation, writes accepted, clr_req starts a sweep
//  SWEEP | clearing entry ptr each cycle, writes dropped, reads allowed
module regfile_2p #(
   parameter  int WIDTH  = 4,
   parameter  int DEPTH  = 4,
   parameter  int BYPASS = 1,
   localparam int AW     = $clog2(DEPTH),
   localparam int CW     = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             wr_enb,
   input  logic [AW-1:0]    wr_sel,
   input  logic             rd_enb,
   input  logic [AW-1:0]    rd_sel,
   input  logic             clr_req,
   output logic [WIDTH-1:0] data_out,
   output logic             rd_valid,
   output logic             rd_hit,
   output logic             busy,
   output logic             wr_err,
   output logic [CW-1:0]    occupancy
);

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0] FULL  = CW'(DEPTH);

   state_t          state_q, state_d;
   logic [AW-1:0]   ptr_q, ptr_d;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0] valid_q;

   logic             sweep_clr;
   logic             wr_in_range;
   logic             rd_in_range;
   logic             wr_ok;
   logic             occ_inc;
   logic             occ_dec;
   logic [WIDTH-1:0] rd_data_d;
   logic             rd_hit_d;

   assign busy        = (state_q == SWEEP);
   assign sweep_clr   = (state_q == SWEEP);
   assign wr_in_range = ({1'b0, wr_sel} < DEPTH_W);
   assign rd_in_range = ({1'b0, rd_sel} < DEPTH_W);
   assign wr_ok       = wr_enb & ~busy & wr_in_range;

   // Write and sweep never overlap, so occupancy moves by at most one.
   assign occ_inc = wr_ok & ~valid_q[wr_sel] & (occupancy != FULL);
   assign occ_dec = sweep_clr & valid_q[ptr_q] & (occupancy != '0);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = SWEEP;
               ptr_d   = '0;
            end
         end
         SWEEP: begin
            if (ptr_q == AW'(DEPTH - 1)) begin
               state_d = IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + AW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Read sees pre-edge contents; forwarding overrides only for an accepted write.
   always_comb begin
      rd_data_d = '0;
      rd_hit_d  = 1'b0;
      if ((BYPASS != 0) && wr_ok && (wr_sel == rd_sel)) begin
         rd_data_d = data_in;
         rd_hit_d  = 1'b1;
      end else if (rd_in_range && valid_q[rd_sel]) begin
         rd_data_d = mem_q[rd_sel];
         rd_hit_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         valid_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (sweep_clr && (ptr_q == AW'(i))) begin
               mem_q[i]   <= '0;
               valid_q[i] <= 1'b0;
            end else if (wr_ok && (wr_sel == AW'(i))) begin
               mem_q[i]   <= data_in;
               valid_q[i] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out  <= '0;
         rd_hit    <= 1'b0;
         rd_valid  <= 1'b0;
         wr_err    <= 1'b0;
         occupancy <= '0;
      end else begin
         if (rd_enb) begin
            data_out <= rd_data_d;
            rd_hit   <= rd_hit_d;
         end
         rd_valid <= rd_enb;
         wr_err   <= wr_enb & ~wr_ok;
         if (occ_inc) begin
            occupancy <= occupancy + CW'(1);
         end else if (occ_dec) begin
            occupancy <= occupancy - CW'(1);
         end
      end
   end

endmodule
